// File: rtl/blit_outer_pkg.sv
// Shared types and bit positions for the blitter outer-loop sequencer.
// Optional macro BLIT_OUTER_CNTRD_EN exposes the remaining count in the status word.
package blit_outer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_INNER,
        ST_WAIT,
        ST_UPDATE,
        ST_CHECK,
        ST_DONE
    } state_e;

    localparam int CMD_RUN     = 0;
    localparam int CMD_ABORT   = 1;
    localparam int CMD_INTEN   = 2;
    localparam int CMD_PRIO    = 3;
    localparam int CMD_FRAC    = 7;
    localparam int CMD_UPD_LSB = 8;

    localparam int STAT_NIDLE   = 0;
    localparam int STAT_STOP    = 1;
    localparam int STAT_DONE    = 2;
    localparam int STAT_CNT_LSB = 4;
    localparam int STAT_CNT_W   = 12;

endpackage

// File: rtl/blit_outer_cnt.sv
// Loadable outer-loop down-counter; saturates at zero and flags zero / last iteration.
module blit_outer_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] count_o,
    output logic             zero_o,
    output logic             last_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);
    // Decrementing from 1 (or a saturated 0) leaves zero: the loop ends here.
    assign last_o  = (count_q <= CNT_W'(1));

endmodule

// File: rtl/blit_outer_seq.sv
// Blitter outer-loop sequencer: FSM, done/interrupt flags and status word.
// Optional macro BLIT_OUTER_CNTRD_EN puts the remaining count on gpu_dout[15:4].
module blit_outer_seq
    import blit_outer_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int NCH   = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [31:0]     gpu_din,
    input  logic            cmdld,
    input  logic            countld,
    input  logic            statrd,
    input  logic            active,
    input  logic            indone,
    input  logic            stopped,
    output logic [15:0]     gpu_dout,
    output logic            gpu_dout_oe,
    output logic            instart,
    output logic            sshftld,
    output logic [NCH-1:0]  upd,
    output logic            updf,
    output logic [1:0]      blit_breq,
    output logic            blit_int,
    output logic            busy
);

    state_e           state_q;
    logic             inten_q;
    logic             prio_q;
    logic             frac_q;
    logic [NCH-1:0]   upd_en_q;
    logic             done_q;
    logic             int_q;

    logic [CNT_W-1:0] count;
    logic             cnt_zero;
    logic             cnt_last;
    logic             idle;
    logic             cmd_abort;
    logic             cmd_accept;
    logic             flag_set;
    logic             flag_clr;
    logic             unused_bits;

    assign idle       = (state_q == ST_IDLE);
    assign cmd_abort  = cmdld && gpu_din[CMD_ABORT];
    assign cmd_accept = cmdld && !gpu_din[CMD_ABORT] && idle && !stopped;
    assign flag_set   = (state_q == ST_DONE) && !stopped && !cmd_abort;
    assign flag_clr   = statrd || cmd_accept;

    blit_outer_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (countld && idle),
        .load_val_i (gpu_din[16 +: CNT_W]),
        .dec_i      ((state_q == ST_CHECK) && !stopped && !cmd_abort),
        .count_o    (count),
        .zero_o     (cnt_zero),
        .last_o     (cnt_last)
    );

    // Abort overrides everything; otherwise stopped freezes the sequence in place.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            inten_q  <= 1'b0;
            prio_q   <= 1'b0;
            frac_q   <= 1'b0;
            upd_en_q <= '0;
            done_q   <= 1'b0;
            int_q    <= 1'b0;
        end else begin
            if (flag_set) begin
                done_q <= 1'b1;
            end else if (flag_clr) begin
                done_q <= 1'b0;
            end
            if (flag_set && inten_q) begin
                int_q <= 1'b1;
            end else if (flag_clr) begin
                int_q <= 1'b0;
            end

            if (cmd_abort) begin
                state_q <= ST_IDLE;
            end else if (!stopped) begin
                case (state_q)
                    ST_IDLE: begin
                        if (cmd_accept) begin
                            inten_q  <= gpu_din[CMD_INTEN];
                            prio_q   <= gpu_din[CMD_PRIO];
                            frac_q   <= gpu_din[CMD_FRAC];
                            upd_en_q <= gpu_din[CMD_UPD_LSB +: NCH];
                            if (gpu_din[CMD_RUN]) begin
                                state_q <= cnt_zero ? ST_DONE : ST_START;
                            end
                        end
                    end
                    ST_START:  if (active) state_q <= ST_INNER;
                    ST_INNER:  state_q <= ST_WAIT;
                    ST_WAIT:   if (indone) state_q <= ST_UPDATE;
                    ST_UPDATE: state_q <= ST_CHECK;
                    ST_CHECK:  state_q <= cnt_last ? ST_DONE : ST_INNER;
                    ST_DONE:   state_q <= ST_IDLE;
                    default:   state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign busy        = !idle;
    assign blit_int    = int_q;
    assign gpu_dout_oe = statrd;
    assign instart     = (state_q == ST_INNER) && !stopped;
    assign sshftld     = (state_q == ST_INNER) && !stopped;
    assign upd         = ((state_q == ST_UPDATE) && !stopped) ? upd_en_q : '0;
    assign updf        = (state_q == ST_UPDATE) && !stopped && upd_en_q[0] && frac_q;
    assign blit_breq   = ((state_q inside {ST_START, ST_INNER, ST_WAIT, ST_UPDATE, ST_CHECK})
                          && !stopped) ? {prio_q, 1'b1} : 2'b00;

    always_comb begin
        gpu_dout             = '0;
        gpu_dout[STAT_NIDLE] = idle;
        gpu_dout[STAT_STOP]  = stopped;
        gpu_dout[STAT_DONE]  = done_q;
`ifdef BLIT_OUTER_CNTRD_EN
        gpu_dout[STAT_CNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(count);
`endif
    end

    assign unused_bits = ^{gpu_din, count};

endmodule
